cordic_phase_arbiter: RTL and testbench
=======================================

CORDIC_PHASE_ARBITER -- requirements
Module: cordic_phase_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL expose these parameters, one per line as name, default, meaning:
- NUM_REQ, 4, number of phase requesters sharing one CORDIC sin/cos engine.
- A_BITS, 16, angle width.
- OUT_BITS, 16, result width.
- TAG_DEPTH, 32, maximum in-flight CORDIC operations (power of 2).
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- REQ_VALID  in  NUM_REQ  per-requester angle valid.
- REQ_ANGLE  in  NUM_REQ*A_BITS  packed angles; requester i at [i*A_BITS +: A_BITS].
- REQ_READY  out  NUM_REQ  one-hot grant.
- FLUSH  in  1  stop issuing and drain in-flight operations.
- FLUSH_DONE  out  1  one-cycle pulse when the drain completes.
- CORDIC_DIN_A  out  A_BITS  angle to the engine.
- CORDIC_DIN_VALID  out  1  engine input strobe.
- CORDIC_DOUT_VALID  in  1  engine result strobe.
- CORDIC_DOUT_X  in  OUT_BITS  cosine result.
- CORDIC_DOUT_Y  in  OUT_BITS  sine result.
- RSP_VALID  out  NUM_REQ  one-hot result strobe.
- RSP_X  out  OUT_BITS  routed cosine.
- RSP_Y  out  OUT_BITS  routed sine.
- ERR_SPURIOUS  out  1  sticky flag: result received with no tag outstanding.

Function
REQ-004 Handshake SHALL follow valid/ready: a transfer occurs when REQ_VALID[i] and REQ_READY[i] are both high; REQ_READY SHALL be combinational and at most one bit high per cycle.
REQ-005 Grant SHALL be round-robin: the search starts at (last granted index + 1) mod NUM_REQ and wraps around.
REQ-006 No grant SHALL be issued when the in-flight count equals TAG_DEPTH; a pop in the same cycle SHALL NOT free a slot until the next cycle.
REQ-007 On a grant, CORDIC_DIN_A and CORDIC_DIN_VALID SHALL be registered, giving exactly one cycle from handshake to strobe.
REQ-008 The granted index SHALL be pushed into the tag FIFO in the same cycle as CORDIC_DIN_VALID.
REQ-009 On CORDIC_DOUT_VALID with the FIFO non-empty, the block SHALL pop the tag and register RSP_X/RSP_Y with RSP_VALID[tag]=1, giving one cycle of latency.
REQ-010 On CORDIC_DOUT_VALID with the FIFO empty, the block SHALL set ERR_SPURIOUS, pop nothing, and drive no RSP_VALID.
REQ-011 A push and a pop in the same cycle SHALL leave the count unchanged and preserve ordering.
REQ-012 The FSM SHALL have three states:
- RUN: grants enabled; FLUSH=1 moves to DRAIN.
- DRAIN: all REQ_READY=0; moves to DONE when the count is 0 and no CORDIC_DIN_VALID is pending.
- DONE: FLUSH_DONE=1 for one cycle, then return to RUN.
REQ-013 FLUSH asserted in DRAIN or DONE SHALL be ignored.

Reset
REQ-014 RST SHALL force all of the following, with no response emitted for operations in flight:
- REQ_READY, CORDIC_DIN_VALID, RSP_VALID, FLUSH_DONE and ERR_SPURIOUS to 0.
- CORDIC_DIN_A, RSP_X and RSP_Y to 0.
- Round-robin pointer so that requester 0 is searched first.
- FIFO empty and count 0.
- FSM state RUN.
REQ-015 The CORDIC engine SHALL be reset by the same RST, so no stale results arrive after reset.

Configuration
REQ-016 With CORDIC_ARB_PRIO0_EN defined, requester 0 SHALL win whenever REQ_VALID[0]=1 and a slot is free, and the round-robin pointer SHALL rotate only among requesters 1..NUM_REQ-1.
REQ-017 Without CORDIC_ARB_PRIO0_EN, all requesters SHALL be arbitrated purely round-robin.

Structure
REQ-018 Package cordic_arb_pkg SHALL hold:
- Default parameters.
- TAG_W = $clog2(NUM_REQ).
- CNT_W = $clog2(TAG_DEPTH)+1.
- FSM state enum {RUN, DRAIN, DONE}.
REQ-019 The tag FIFO SHALL be the sub-module cordic_arb_tag_fifo, with synchronous push/pop, registered count, and full/empty outputs.

Verification
REQ-020 The bench SHALL cover these directed scenarios, modelling the CORDIC with a fixed 18-cycle latency:
- All 4 requesters valid continuously -> grants 0,1,2,3,0,... one per cycle; each RSP_VALID[i] returns with its own angle's result.
- Angle 0x4000 from requester 2 -> CORDIC_DIN_A=0x4000 one cycle later; RSP_VALID=4'b0100 exactly 20 cycles after the handshake.
- TAG_DEPTH=4 with the model stalled -> exactly 4 grants, then REQ_READY=0 until the first CORDIC_DOUT_VALID; grants resume on the following cycle.
- 5 operations in flight, then FLUSH=1 -> no grants; FLUSH_DONE pulses one cycle after the 5th RSP_VALID.
- CORDIC_DOUT_VALID injected with the FIFO empty -> ERR_SPURIOUS=1 and held until RST; no RSP_VALID.
- RST mid-stream with 3 in flight -> all outputs 0 next cycle; first grant after release goes to requester 0 (under CORDIC_ARB_PRIO0_EN, requester 0 wins over 1..3 every cycle).

Source files
------------

// File: rtl/cordic_arb_pkg.sv
// Shared definitions for the CORDIC phase arbiter slice.
// Holds the default parameters, the tag/count width helpers and the arbiter FSM state type.
// No ports: compile-time definitions only.
package cordic_arb_pkg;

  localparam int unsigned NUM_REQ_DEF   = 4;
  localparam int unsigned A_BITS_DEF    = 16;
  localparam int unsigned OUT_BITS_DEF  = 16;
  localparam int unsigned TAG_DEPTH_DEF = 32;

  // Width of a requester index; a single requester still needs a 1-bit tag.
  function automatic int unsigned tag_w_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Count must represent 0..depth inclusive.
  function automatic int unsigned cnt_w_of(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned TAG_W = $clog2(NUM_REQ_DEF);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH_DEF) + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/cordic_arb_tag_fifo.sv
// Tag FIFO remembering which requester owns each in-flight CORDIC operation.
// Synchronous push/pop, registered occupancy count, show-ahead read data.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset (empties the FIFO)
//   push_i/push_data_i  write a tag (ignored when full)
//   pop_i               discard the head tag (ignored when empty)
//   pop_data_o          head tag, valid whenever empty_o is low
//   count_o             current occupancy, 0..DEPTH
//   full_o, empty_o     occupancy flags derived from the registered count
module cordic_arb_tag_fifo
  import cordic_arb_pkg::*;
#(
  parameter int unsigned DEPTH = TAG_DEPTH_DEF,
  parameter int unsigned WIDTH = TAG_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cordic_phase_arbiter.sv
// Round-robin arbiter sharing one pipelined CORDIC sin/cos engine among NUM_REQ requesters.
// Each granted angle is registered to the engine; its requester index rides a tag FIFO
// and is used to route the returning result back as a one-hot response strobe.
// Optional feature: define CORDIC_ARB_PRIO0_EN to give requester 0 absolute priority, with
// round-robin among requesters 1..NUM_REQ-1.
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   REQ_VALID/REQ_ANGLE        per-requester valid and packed angles
//   REQ_READY                  combinational one-hot grant
//   FLUSH/FLUSH_DONE           stop issuing and drain; one-cycle completion pulse
//   CORDIC_DIN_A/_VALID        registered angle and strobe to the engine
//   CORDIC_DOUT_VALID/_X/_Y    engine result
//   RSP_VALID/RSP_X/RSP_Y      routed registered result
//   ERR_SPURIOUS               sticky: result arrived with no tag outstanding
module cordic_phase_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned A_BITS    = A_BITS_DEF,
  parameter int unsigned OUT_BITS  = OUT_BITS_DEF,
  parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ*A_BITS-1:0] REQ_ANGLE,
  output logic [NUM_REQ-1:0]        REQ_READY,
  input  logic                      FLUSH,
  output logic                      FLUSH_DONE,
  output logic [A_BITS-1:0]         CORDIC_DIN_A,
  output logic                      CORDIC_DIN_VALID,
  input  logic                      CORDIC_DOUT_VALID,
  input  logic [OUT_BITS-1:0]       CORDIC_DOUT_X,
  input  logic [OUT_BITS-1:0]       CORDIC_DOUT_Y,
  output logic [NUM_REQ-1:0]        RSP_VALID,
  output logic [OUT_BITS-1:0]       RSP_X,
  output logic [OUT_BITS-1:0]       RSP_Y,
  output logic                      ERR_SPURIOUS
);

  localparam int unsigned TW = tag_w_of(NUM_REQ);
  localparam int unsigned CW = cnt_w_of(TAG_DEPTH);

  arb_state_e state_q, state_d;
  logic       run_en;

  logic [TW-1:0]       last_q;
  logic [TW-1:0]       grant_idx;
  logic                grant_any;
  logic [NUM_REQ-1:0]  grant;
  logic [A_BITS-1:0]   grant_angle;
  logic                issue_en;

  logic [A_BITS-1:0]   din_a_q;
  logic                din_valid_q;
  logic [TW-1:0]       tag_q;

  logic [CW-1:0]       fifo_count;
  logic                fifo_full, fifo_empty;
  logic [TW-1:0]       pop_tag;
  logic                pop, spurious;
  logic [CW:0]         inflight;
  logic                drain_idle;
  logic [NUM_REQ-1:0]  pop_onehot;

  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [OUT_BITS-1:0] rsp_x_q, rsp_y_q;
  logic                err_q;

  // A granted operation sits one cycle in the input register before it reaches the FIFO,
  // so it must already count as in flight or a full FIFO could be overrun.
  assign inflight   = {1'b0, fifo_count} + {{CW{1'b0}}, din_valid_q};
  assign issue_en   = run_en && !FLUSH && !RST && !fifo_full &&
                      (inflight < (CW + 1)'(TAG_DEPTH));
  assign drain_idle = (fifo_count == '0) && !din_valid_q;
  assign pop        = CORDIC_DOUT_VALID && !fifo_empty;
  assign spurious   = CORDIC_DOUT_VALID && fifo_empty;

  always_comb begin
    logic [TW-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    if (issue_en) begin
`ifdef CORDIC_ARB_PRIO0_EN
      if (REQ_VALID[0]) begin
        grant_any = 1'b1;
      end else begin
        // last_q stays within 1..NUM_REQ-1 in this mode.
        for (int unsigned off = 0; off < NUM_REQ - 1; off++) begin
          idx = TW'(32'd1 + ((32'(last_q) + off) % (NUM_REQ - 1)));
          if (!grant_any && REQ_VALID[idx]) begin
            grant_any = 1'b1;
            grant_idx = idx;
          end
        end
      end
`else
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        idx = TW'((32'(last_q) + 32'd1 + off) % NUM_REQ);
        if (!grant_any && REQ_VALID[idx]) begin
          grant_any = 1'b1;
          grant_idx = idx;
        end
      end
`endif
    end
  end

  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign REQ_READY = grant;

  always_comb begin
    grant_angle = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TW'(i)) begin
        grant_angle = REQ_ANGLE[i*A_BITS +: A_BITS];
      end
    end
  end

  always_comb begin
    pop_onehot = '0;
    if (pop) begin
      pop_onehot[pop_tag] = 1'b1;
    end
  end

  cordic_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TW)
  ) u_tag_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (din_valid_q),
    .push_data_i (tag_q),
    .pop_i       (pop),
    .pop_data_o  (pop_tag),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Issue side: engine input register, tag holding register, round-robin pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      din_a_q     <= '0;
      din_valid_q <= 1'b0;
      tag_q       <= '0;
      last_q      <= TW'(NUM_REQ - 1);
    end else begin
      din_valid_q <= grant_any;
      if (grant_any) begin
        din_a_q <= grant_angle;
        tag_q   <= grant_idx;
      end
`ifdef CORDIC_ARB_PRIO0_EN
      if (grant_any && (grant_idx != '0)) begin
        last_q <= grant_idx;
      end
`else
      if (grant_any) begin
        last_q <= grant_idx;
      end
`endif
    end
  end

  // Return side: routed response register and sticky spurious flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid_q <= '0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= pop_onehot;
      if (pop) begin
        rsp_x_q <= CORDIC_DOUT_X;
        rsp_y_q <= CORDIC_DOUT_Y;
      end
      if (spurious) begin
        err_q <= 1'b1;
      end
    end
  end

  assign CORDIC_DIN_A     = din_a_q;
  assign CORDIC_DIN_VALID = din_valid_q;
  assign RSP_VALID        = rsp_valid_q;
  assign RSP_X            = rsp_x_q;
  assign RSP_Y            = rsp_y_q;
  assign ERR_SPURIOUS     = err_q;

  // FSM: state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. FLUSH only matters in RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (FLUSH) state_d = DRAIN;
      DRAIN:   if (drain_idle) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    run_en     = (state_q == RUN);
    FLUSH_DONE = (state_q == DONE);
  end

endmodule

// File: tb/tb_cordic_phase_arbiter.sv
module tb_cordic_phase_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] fx(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] fy(input logic [15:0] a);
    return a + 16'h0101;
  endfunction

  // DUT A: default depth, driven by an 18-cycle CORDIC stand-in.
  logic [3:0]  a_req_valid = '0;
  logic [63:0] a_req_angle = '0;
  logic [3:0]  a_req_ready, a_rsp_valid;
  logic        a_flush = 1'b0, a_flush_done, a_din_valid, a_dout_valid, a_err;
  logic [15:0] a_din_a, a_dout_x, a_dout_y, a_rsp_x, a_rsp_y;
  logic        a_inject = 1'b0;

  cordic_phase_arbiter u_dut (
    .CLK (clk), .RST (rst),
    .REQ_VALID (a_req_valid), .REQ_ANGLE (a_req_angle), .REQ_READY (a_req_ready),
    .FLUSH (a_flush), .FLUSH_DONE (a_flush_done),
    .CORDIC_DIN_A (a_din_a), .CORDIC_DIN_VALID (a_din_valid),
    .CORDIC_DOUT_VALID (a_dout_valid), .CORDIC_DOUT_X (a_dout_x), .CORDIC_DOUT_Y (a_dout_y),
    .RSP_VALID (a_rsp_valid), .RSP_X (a_rsp_x), .RSP_Y (a_rsp_y),
    .ERR_SPURIOUS (a_err)
  );

  logic [17:0] pv;
  logic [15:0] pa [18];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < 18; i++) pa[i] <= '0;
    end else begin
      pv    <= {pv[16:0], a_din_valid};
      pa[0] <= a_din_a;
      for (int i = 1; i < 18; i++) pa[i] <= pa[i-1];
    end
  end
  assign a_dout_valid = pv[17] | a_inject;
  assign a_dout_x     = fx(pa[17]);
  assign a_dout_y     = fy(pa[17]);

  // DUT B: TAG_DEPTH=4 with a hand-driven (stalled) engine.
  logic [3:0]  b_req_valid = '0;
  logic [63:0] b_req_angle = {16'hD004, 16'hC003, 16'hB002, 16'hA001};
  logic [3:0]  b_req_ready, b_rsp_valid;
  logic        b_flush = 1'b0, b_flush_done, b_din_valid, b_dout_valid = 1'b0, b_err;
  logic [15:0] b_din_a, b_rsp_x, b_rsp_y;
  logic [15:0] b_dout_x = 16'h7777, b_dout_y = 16'h8888;

  cordic_phase_arbiter #(.TAG_DEPTH (4)) u_dut4 (
    .CLK (clk), .RST (rst),
    .REQ_VALID (b_req_valid), .REQ_ANGLE (b_req_angle), .REQ_READY (b_req_ready),
    .FLUSH (b_flush), .FLUSH_DONE (b_flush_done),
    .CORDIC_DIN_A (b_din_a), .CORDIC_DIN_VALID (b_din_valid),
    .CORDIC_DOUT_VALID (b_dout_valid), .CORDIC_DOUT_X (b_dout_x), .CORDIC_DOUT_Y (b_dout_y),
    .RSP_VALID (b_rsp_valid), .RSP_X (b_rsp_x), .RSP_Y (b_rsp_y),
    .ERR_SPURIOUS (b_err)
  );

  typedef struct {int cyc; logic [3:0] oh; logic [15:0] x; logic [15:0] y;} rsp_t;
  rsp_t rsp_log[$];
  rsp_t exp_q[$];
  always @(negedge clk) begin
    if (!rst && a_rsp_valid != '0)
      rsp_log.push_back('{cyc: cyc, oh: a_rsp_valid, x: a_rsp_x, y: a_rsp_y});
  end

  typedef struct {logic [3:0] valid; logic [3:0] ready; logic [15:0] din_a;} vec_t;
  vec_t tbl[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_ready"}, a_req_ready, 0);
    chk({tag, "_din_valid"}, a_din_valid, 0);
    chk({tag, "_din_a"}, a_din_a, 0);
    chk({tag, "_rsp_valid"}, a_rsp_valid, 0);
    chk({tag, "_rsp_x"}, a_rsp_x, 0);
    chk({tag, "_rsp_y"}, a_rsp_y, 0);
    chk({tag, "_flush_done"}, a_flush_done, 0);
    chk({tag, "_err"}, a_err, 0);
  endtask

  initial begin
    logic [3:0] b_exp [8];
    int h, n_rsp, last_rsp, done_cyc, bad;
    logic found, done_seen;

    // Hand-computed round-robin sequence; pointer starts so requester 0 is searched first.
    tbl[0]  = '{4'b1111, 4'b0001, 16'h0111};
    tbl[1]  = '{4'b1111, 4'b0010, 16'h1222};
    tbl[2]  = '{4'b1111, 4'b0100, 16'h2333};
    tbl[3]  = '{4'b1111, 4'b1000, 16'h3444};
    tbl[4]  = '{4'b1111, 4'b0001, 16'h0111};
    tbl[5]  = '{4'b0000, 4'b0000, 16'h0000};
    tbl[6]  = '{4'b1001, 4'b1000, 16'h3444};
    tbl[7]  = '{4'b1001, 4'b0001, 16'h0111};
    tbl[8]  = '{4'b0100, 4'b0100, 16'h2333};
    tbl[9]  = '{4'b0110, 4'b0010, 16'h1222};
    tbl[10] = '{4'b0110, 4'b0100, 16'h2333};
    tbl[11] = '{4'b0011, 4'b0001, 16'h0111};
    b_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0};
`ifdef CORDIC_ARB_PRIO0_EN
    for (int i = 1; i < 4; i++) tbl[i] = '{4'b1111, 4'b0001, 16'h0111};
    tbl[6] = '{4'b1001, 4'b0001, 16'h0111};
    b_exp  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0};
`endif

    // Reset state.
    a_req_valid = 4'b1111;
    @(negedge clk);
    chk_a_zero("reset");
    step();
    step();
    rst = 1'b0;
    a_req_valid = '0;

    // Depth-4 instance with a stalled engine.
    b_req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("depth4_grant%0d", k), b_req_ready, b_exp[k]);
      step();
    end
    b_dout_valid = 1'b1;
    @(negedge clk);
    chk("depth4_pop_same_cycle", b_req_ready, 0);
    step();
    b_dout_valid = 1'b0;
    @(negedge clk);
    chk("depth4_resume", b_req_ready, 4'b0001);
    chk("depth4_rsp_valid", b_rsp_valid, 4'b0001);
    chk("depth4_rsp_x", b_rsp_x, 16'h7777);
    chk("depth4_rsp_y", b_rsp_y, 16'h8888);
    step();
    b_req_valid = '0;

    // Table-driven arbitration and routing.
    a_req_angle = {16'h3444, 16'h2333, 16'h1222, 16'h0111};
    rsp_log.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      a_req_valid = tbl[i].valid;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), a_req_ready, tbl[i].ready);
      step();
      chk($sformatf("tbl%0d_din_valid", i), a_din_valid, (tbl[i].ready != 0));
      if (tbl[i].ready != 0) begin
        chk($sformatf("tbl%0d_din_a", i), a_din_a, tbl[i].din_a);
        exp_q.push_back('{cyc: 0, oh: tbl[i].ready, x: fx(tbl[i].din_a), y: fy(tbl[i].din_a)});
      end
    end
    a_req_valid = '0;
    repeat (30) step();
    chk("tbl_rsp_count", rsp_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rsp_log.size(); k++) begin
      chk($sformatf("tbl_rsp%0d_oh", k), rsp_log[k].oh, exp_q[k].oh);
      chk($sformatf("tbl_rsp%0d_x", k), rsp_log[k].x, exp_q[k].x);
      chk($sformatf("tbl_rsp%0d_y", k), rsp_log[k].y, exp_q[k].y);
    end

    // Single angle latency: strobe one cycle later, response 20 cycles after handshake.
    a_req_angle[2*16 +: 16] = 16'h4000;
    a_req_valid = 4'b0100;
    @(negedge clk);
    h = cyc;
    chk("lat_ready", a_req_ready, 4'b0100);
    step();
    a_req_valid = '0;
    chk("lat_din_valid", a_din_valid, 1);
    chk("lat_din_a", a_din_a, 16'h4000);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (a_rsp_valid != '0) begin
        found = 1'b1;
        chk("lat_cycles", cyc - h, 20);
        chk("lat_rsp_oh", a_rsp_valid, 4'b0100);
        chk("lat_rsp_x", a_rsp_x, fx(16'h4000));
        chk("lat_rsp_y", a_rsp_y, fy(16'h4000));
      end
    end
    chk("lat_rsp_seen", found, 1);
    repeat (3) step();

    // Flush with 5 in flight.
    a_req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("flush_pre_grant%0d", k), (a_req_ready != 0), 1);
      step();
    end
    a_flush = 1'b1;
    n_rsp = 0; last_rsp = 0; done_cyc = 0; bad = 0; done_seen = 1'b0;
    for (int n = 0; n < 80 && !done_seen; n++) begin
      @(negedge clk);
      if (a_req_ready != '0) bad++;
      if (a_rsp_valid != '0) begin
        n_rsp++;
        last_rsp = cyc;
      end
      if (a_flush_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      step();
      if (n == 2) a_flush = 1'b0;
    end
    a_flush = 1'b0;
    chk("flush_done_seen", done_seen, 1);
    chk("flush_no_grants", bad, 0);
    chk("flush_rsp_count", n_rsp, 5);
    chk("flush_done_delay", done_cyc - last_rsp, 1);
    @(negedge clk);
    chk("flush_done_pulse", a_flush_done, 0);
    chk("flush_resume", (a_req_ready != 0), 1);
    step();
    a_req_valid = '0;
    repeat (30) step();

    // Spurious result with nothing outstanding.
    chk("spur_err_before", a_err, 0);
    a_inject = 1'b1;
    step();
    a_inject = 1'b0;
    chk("spur_err_set", a_err, 1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_rsp_valid != '0) bad++;
      step();
    end
    chk("spur_no_rsp", bad, 0);
    chk("spur_err_held", a_err, 1);

    // Reset mid-stream with 3 in flight.
    a_req_valid = 4'b1111;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk_a_zero("midrst");
    chk("midrst_b_ready", b_req_ready, 0);
    chk("midrst_b_rsp_valid", b_rsp_valid, 0);
    step();
    step();
    rst = 1'b0;
    rsp_log.delete();
    @(negedge clk);
    chk("postrst_grant0", a_req_ready, 4'b0001);
    step();
    @(negedge clk);
`ifdef CORDIC_ARB_PRIO0_EN
    chk("postrst_grant1", a_req_ready, 4'b0001);
`else
    chk("postrst_grant1", a_req_ready, 4'b0010);
`endif
    step();
    a_req_valid = '0;
    repeat (30) step();
    chk("postrst_rsp_count", rsp_log.size(), 2);
    if (rsp_log.size() > 0) chk("postrst_rsp0_oh", rsp_log[0].oh, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
